// File: rtl/rv32v_wb_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rv32v_wb_sequencer (with package rv32v_wb_pkg)                    |
// | Purpose : Writer side of the vector register-file port. Accepts one result  |
// |           header, then streams NUM_LANES-wide data beats to the RF write    |
// |           port one beat per cycle until vl elements have been covered.      |
// |           Reports busy/busy_vd to hazard logic.                             |
// | Ports   : clk_i, rst_i (sync, active-high), flush_i                         |
// |           hdr_valid_i/hdr_ready_o, hdr_vd_i, hdr_sew_i, hdr_vl_i,           |
// |           hdr_single_bit_i       : result header handshake                  |
// |           data_valid_i/data_ready_o, data_i : data beat handshake           |
// |           w_data_o, vd_o, wen_o, vd_offset_o, wb_sew_o, wb_vl_o,            |
// |           write_single_bit_o     : registered RF writeback port             |
// |           done_o (1-cycle pulse), busy_o, busy_vd_o : status/hazard         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

package rv32v_wb_pkg;
  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } sew_t;
endpackage

module rv32v_wb_sequencer
  import rv32v_wb_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int VL_WIDTH  = 6,
  parameter int OFFSET_W  = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    hdr_valid_i,
  output logic                    hdr_ready_o,
  input  logic [4:0]              hdr_vd_i,
  input  sew_t                    hdr_sew_i,
  input  logic [VL_WIDTH-1:0]     hdr_vl_i,
  input  logic                    hdr_single_bit_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  input  logic [NUM_LANES*32-1:0] data_i,
  output logic [NUM_LANES*32-1:0] w_data_o,
  output logic [4:0]              vd_o,
  output logic                    wen_o,
  output logic [OFFSET_W-1:0]     vd_offset_o,
  output sew_t                    wb_sew_o,
  output logic [VL_WIDTH-1:0]     wb_vl_o,
  output logic                    write_single_bit_o,
  output logic                    done_o,
  output logic                    busy_o,
  output logic [4:0]              busy_vd_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // One extra bit so offset+NUM_LANES never wraps before the last-beat compare.
  localparam logic [VL_WIDTH:0] LANES_INC = (VL_WIDTH + 1)'(NUM_LANES);

  state_t                  state_q, state_d;
  logic [4:0]              lat_vd_q, lat_vd_d;
  sew_t                    lat_sew_q, lat_sew_d;
  logic [VL_WIDTH-1:0]     lat_vl_q, lat_vl_d;
  logic                    lat_sb_q, lat_sb_d;
  logic [VL_WIDTH:0]       offset_q, offset_d;

  logic                    hdr_ready_q, hdr_ready_d;
  logic                    data_ready_q, data_ready_d;
  logic [NUM_LANES*32-1:0] w_data_q, w_data_d;
  logic [4:0]              vd_q, vd_d;
  logic                    wen_q, wen_d;
  logic [OFFSET_W-1:0]     vd_offset_q, vd_offset_d;
  sew_t                    wb_sew_q, wb_sew_d;
  logic [VL_WIDTH-1:0]     wb_vl_q, wb_vl_d;
  logic                    wsb_q, wsb_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic [4:0]              busy_vd_q, busy_vd_d;

  logic                    hdr_acc;
  logic                    beat_acc;
  logic [VL_WIDTH:0]       offset_next;
  logic                    last_beat;

  // Ready flags are registered copies of the state, so they read 0 in reset.
  assign hdr_acc     = hdr_valid_i & hdr_ready_q;
  assign beat_acc    = data_valid_i & data_ready_q;
  assign offset_next = offset_q + LANES_INC;
  assign last_beat   = (offset_next >= {1'b0, lat_vl_q});

  always_comb begin
    state_d      = state_q;
    lat_vd_d     = lat_vd_q;
    lat_sew_d    = lat_sew_q;
    lat_vl_d     = lat_vl_q;
    lat_sb_d     = lat_sb_q;
    offset_d     = offset_q;
    w_data_d     = w_data_q;
    vd_d         = vd_q;
    vd_offset_d  = vd_offset_q;
    wb_sew_d     = wb_sew_q;
    wb_vl_d      = wb_vl_q;
    wsb_d        = wsb_q;
    busy_vd_d    = busy_vd_q;
    wen_d        = 1'b0;
    done_d       = 1'b0;

    if (flush_i) begin
      // Anything accepted this cycle is squashed; a wen already registered still lands.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hdr_acc) begin
            lat_vd_d  = hdr_vd_i;
            lat_sew_d = hdr_sew_i;
            lat_vl_d  = hdr_vl_i;
            lat_sb_d  = hdr_single_bit_i;
            busy_vd_d = hdr_vd_i;
            offset_d  = '0;
            if (hdr_vl_i == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (beat_acc) begin
            wen_d       = 1'b1;
            w_data_d    = data_i;
            vd_d        = lat_vd_q;
            vd_offset_d = offset_q[OFFSET_W-1:0];
            wb_sew_d    = lat_sew_q;
            wb_vl_d     = lat_vl_q;
            wsb_d       = lat_sb_q;
            offset_d    = offset_next;
            if (last_beat) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    hdr_ready_d  = (state_d == ST_IDLE);
    data_ready_d = (state_d == ST_WRITE);
    busy_d       = (state_d == ST_WRITE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      lat_vd_q     <= '0;
      lat_sew_q    <= SEW8;
      lat_vl_q     <= '0;
      lat_sb_q     <= 1'b0;
      offset_q     <= '0;
      hdr_ready_q  <= 1'b0;
      data_ready_q <= 1'b0;
      w_data_q     <= '0;
      vd_q         <= '0;
      wen_q        <= 1'b0;
      vd_offset_q  <= '0;
      wb_sew_q     <= SEW8;
      wb_vl_q      <= '0;
      wsb_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      busy_vd_q    <= '0;
    end else begin
      state_q      <= state_d;
      lat_vd_q     <= lat_vd_d;
      lat_sew_q    <= lat_sew_d;
      lat_vl_q     <= lat_vl_d;
      lat_sb_q     <= lat_sb_d;
      offset_q     <= offset_d;
      hdr_ready_q  <= hdr_ready_d;
      data_ready_q <= data_ready_d;
      w_data_q     <= w_data_d;
      vd_q         <= vd_d;
      wen_q        <= wen_d;
      vd_offset_q  <= vd_offset_d;
      wb_sew_q     <= wb_sew_d;
      wb_vl_q      <= wb_vl_d;
      wsb_q        <= wsb_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      busy_vd_q    <= busy_vd_d;
    end
  end

  assign hdr_ready_o        = hdr_ready_q;
  assign data_ready_o       = data_ready_q;
  assign w_data_o           = w_data_q;
  assign vd_o               = vd_q;
  assign wen_o              = wen_q;
  assign vd_offset_o        = vd_offset_q;
  assign wb_sew_o           = wb_sew_q;
  assign wb_vl_o            = wb_vl_q;
  assign write_single_bit_o = wsb_q;
  assign done_o             = done_q;
  assign busy_o             = busy_q;
  assign busy_vd_o          = busy_vd_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32v_wb_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_rv32v_wb_sequencer                                             |
// | Purpose : Directed self-checking bench for rv32v_wb_sequencer.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_rv32v_wb_sequencer;
  import rv32v_wb_pkg::*;

  localparam int NUM_LANES = 2;
  localparam int VL_WIDTH  = 6;
  localparam int OFFSET_W  = 5;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    flush_i;
  logic                    hdr_valid_i;
  logic                    hdr_ready_o;
  logic [4:0]              hdr_vd_i;
  sew_t                    hdr_sew_i;
  logic [VL_WIDTH-1:0]     hdr_vl_i;
  logic                    hdr_single_bit_i;
  logic                    data_valid_i;
  logic                    data_ready_o;
  logic [NUM_LANES*32-1:0] data_i;
  logic [NUM_LANES*32-1:0] w_data_o;
  logic [4:0]              vd_o;
  logic                    wen_o;
  logic [OFFSET_W-1:0]     vd_offset_o;
  sew_t                    wb_sew_o;
  logic [VL_WIDTH-1:0]     wb_vl_o;
  logic                    write_single_bit_o;
  logic                    done_o;
  logic                    busy_o;
  logic [4:0]              busy_vd_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  rv32v_wb_sequencer #(
    .NUM_LANES(NUM_LANES),
    .VL_WIDTH (VL_WIDTH),
    .OFFSET_W (OFFSET_W)
  ) u_dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .flush_i           (flush_i),
    .hdr_valid_i       (hdr_valid_i),
    .hdr_ready_o       (hdr_ready_o),
    .hdr_vd_i          (hdr_vd_i),
    .hdr_sew_i         (hdr_sew_i),
    .hdr_vl_i          (hdr_vl_i),
    .hdr_single_bit_i  (hdr_single_bit_i),
    .data_valid_i      (data_valid_i),
    .data_ready_o      (data_ready_o),
    .data_i            (data_i),
    .w_data_o          (w_data_o),
    .vd_o              (vd_o),
    .wen_o             (wen_o),
    .vd_offset_o       (vd_offset_o),
    .wb_sew_o          (wb_sew_o),
    .wb_vl_o           (wb_vl_o),
    .write_single_bit_o(write_single_bit_o),
    .done_o            (done_o),
    .busy_o            (busy_o),
    .busy_vd_o         (busy_vd_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_hdr(input logic [4:0] vd, input sew_t sew,
                          input logic [VL_WIDTH-1:0] vl, input logic sb);
    hdr_valid_i      = 1'b1;
    hdr_vd_i         = vd;
    hdr_sew_i        = sew;
    hdr_vl_i         = vl;
    hdr_single_bit_i = sb;
  endtask

  // Check the RF port after a beat was accepted on the previous edge.
  task automatic chk_write(input string tag, input logic [63:0] dat, input logic [4:0] vd,
                           input int off, input int vl, input logic sb, input logic dn);
    chk({tag, ".wen"}, 64'(wen_o), 64'd1);
    chk({tag, ".data"}, w_data_o, dat);
    chk({tag, ".vd"}, 64'(vd_o), 64'(vd));
    chk({tag, ".off"}, 64'(vd_offset_o), 64'(off));
    chk({tag, ".vl"}, 64'(wb_vl_o), 64'(vl));
    chk({tag, ".sb"}, 64'(write_single_bit_o), 64'(sb));
    chk({tag, ".done"}, 64'(done_o), 64'(dn));
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; hdr_valid_i = 1'b0; hdr_vd_i = '0; hdr_sew_i = SEW8;
    hdr_vl_i = '0; hdr_single_bit_i = 1'b0; data_valid_i = 1'b0; data_i = '0;

    // Reset
    tick(); tick();
    chk("rst.wen", 64'(wen_o), 64'd0);
    chk("rst.done", 64'(done_o), 64'd0);
    chk("rst.busy", 64'(busy_o), 64'd0);
    chk("rst.hdr_ready", 64'(hdr_ready_o), 64'd0);
    chk("rst.data_ready", 64'(data_ready_o), 64'd0);
    rst_i = 1'b0;
    tick();
    chk("post_rst.hdr_ready", 64'(hdr_ready_o), 64'd1);

    // vd=3, vl=5: three back-to-back beats, offsets 0,2,4
    send_hdr(5'd3, SEW32, 6'd5, 1'b0);
    tick();
    hdr_valid_i = 1'b0;
    chk("t1.busy", 64'(busy_o), 64'd1);
    chk("t1.busy_vd", 64'(busy_vd_o), 64'd3);
    chk("t1.hdr_ready", 64'(hdr_ready_o), 64'd0);
    chk("t1.data_ready", 64'(data_ready_o), 64'd1);
    chk("t1.wen0", 64'(wen_o), 64'd0);
    data_valid_i = 1'b1; data_i = 64'h1111_0000_AAAA_0000;
    tick();
    chk_write("t1.b0", 64'h1111_0000_AAAA_0000, 5'd3, 0, 5, 1'b0, 1'b0);
    chk("t1.sew", 64'(wb_sew_o), 64'(SEW32));
    data_i = 64'h2222_0000_BBBB_0000;
    tick();
    chk_write("t1.b1", 64'h2222_0000_BBBB_0000, 5'd3, 2, 5, 1'b0, 1'b0);
    data_i = 64'h3333_0000_CCCC_0000;
    tick();
    chk_write("t1.b2", 64'h3333_0000_CCCC_0000, 5'd3, 4, 5, 1'b0, 1'b1);
    chk("t1.busy_end", 64'(busy_o), 64'd0);
    chk("t1.hdr_ready_end", 64'(hdr_ready_o), 64'd1);
    data_valid_i = 1'b0;
    tick();
    chk("t1.wen_after", 64'(wen_o), 64'd0);
    chk("t1.done_after", 64'(done_o), 64'd0);

    // vl=0: done one cycle after accept, no write, never busy
    send_hdr(5'd5, SEW16, 6'd0, 1'b0);
    tick();
    hdr_valid_i = 1'b0;
    chk("t2.done", 64'(done_o), 64'd1);
    chk("t2.wen", 64'(wen_o), 64'd0);
    chk("t2.busy", 64'(busy_o), 64'd0);
    chk("t2.hdr_ready", 64'(hdr_ready_o), 64'd1);
    tick();
    chk("t2.done_after", 64'(done_o), 64'd0);
    chk("t2.wen_after", 64'(wen_o), 64'd0);

    // vl=4 with data_valid 1,0,0,1
    send_hdr(5'd10, SEW16, 6'd4, 1'b0);
    tick();
    hdr_valid_i = 1'b0;
    data_valid_i = 1'b1; data_i = 64'h0000_0002_0000_0001;
    tick();
    chk_write("t3.b0", 64'h0000_0002_0000_0001, 5'd10, 0, 4, 1'b0, 1'b0);
    data_valid_i = 1'b0; data_i = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    chk("t3.gap1.wen", 64'(wen_o), 64'd0);
    chk("t3.gap1.off", 64'(vd_offset_o), 64'd0);
    tick();
    chk("t3.gap2.wen", 64'(wen_o), 64'd0);
    chk("t3.gap2.busy", 64'(busy_o), 64'd1);
    data_valid_i = 1'b1; data_i = 64'h0000_0004_0000_0003;
    tick();
    chk_write("t3.b1", 64'h0000_0004_0000_0003, 5'd10, 2, 4, 1'b0, 1'b1);
    data_valid_i = 1'b0;
    tick();

    // vl=8, flush together with the second beat
    send_hdr(5'd12, SEW32, 6'd8, 1'b0);
    tick();
    hdr_valid_i = 1'b0;
    data_valid_i = 1'b1; data_i = 64'h0123_4567_89AB_CDEF;
    tick();
    chk_write("t4.b0", 64'h0123_4567_89AB_CDEF, 5'd12, 0, 8, 1'b0, 1'b0);
    data_i = 64'hFEDC_BA98_7654_3210; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; data_valid_i = 1'b0;
    chk("t4.flush.wen", 64'(wen_o), 64'd0);
    chk("t4.flush.done", 64'(done_o), 64'd0);
    chk("t4.flush.busy", 64'(busy_o), 64'd0);
    chk("t4.flush.hdr_ready", 64'(hdr_ready_o), 64'd1);
    chk("t4.flush.data_ready", 64'(data_ready_o), 64'd0);
    send_hdr(5'd7, SEW8, 6'd2, 1'b0);
    tick();
    hdr_valid_i = 1'b0;
    chk("t4.next.busy", 64'(busy_o), 64'd1);
    chk("t4.next.busy_vd", 64'(busy_vd_o), 64'd7);
    data_valid_i = 1'b1; data_i = 64'h5555_5555_6666_6666;
    tick();
    chk_write("t4.next.b0", 64'h5555_5555_6666_6666, 5'd7, 0, 2, 1'b0, 1'b1);
    data_valid_i = 1'b0;
    tick();

    // single-bit result, hdr_valid held during WRITE
    send_hdr(5'd20, SEW32, 6'd4, 1'b1);
    tick();
    chk("t5.hdr_ready0", 64'(hdr_ready_o), 64'd0);
    data_valid_i = 1'b1; data_i = 64'h0000_000F_0000_000E;
    tick();
    chk_write("t5.b0", 64'h0000_000F_0000_000E, 5'd20, 0, 4, 1'b1, 1'b0);
    chk("t5.hdr_ready1", 64'(hdr_ready_o), 64'd0);
    data_i = 64'h0000_0011_0000_0010;
    tick();
    chk_write("t5.b1", 64'h0000_0011_0000_0010, 5'd20, 2, 4, 1'b1, 1'b1);
    chk("t5.hdr_ready_done", 64'(hdr_ready_o), 64'd1);
    data_valid_i = 1'b0;
    send_hdr(5'd21, SEW32, 6'd4, 1'b1);
    tick();
    hdr_valid_i = 1'b0;
    chk("t5.rehdr.busy", 64'(busy_o), 64'd1);
    chk("t5.rehdr.busy_vd", 64'(busy_vd_o), 64'd21);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t5.end.busy", 64'(busy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
